// File: rtl/pla_sweep_ctrl.sv
// rtl/pla_sweep_ctrl.sv - exhaustive PLA sweep, onset count and alpha-autosymmetry check
// Optional signature output `sig` (CRC-16-CCITT of the truth table) under PLA_SWEEP_CRC_EN.
module pla_sweep_ctrl #(
  parameter int N_IN     = 9,
  parameter int EVAL_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [N_IN-1:0] alpha,
  output logic [N_IN-1:0] x_out,
  output logic            x_valid,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   onset_cnt,
  output logic            sym_ok,
  output logic [N_IN-1:0] mism_idx
`ifdef PLA_SWEEP_CRC_EN
  ,
  output logic [15:0]     sig
`endif
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, CHECK, FIN} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [N_IN-1:0]   alpha_q, alpha_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]  tt_q, tt_d;
  logic [N_IN:0]     onset_q, onset_d;
  logic              sym_q, sym_d;
  logic [N_IN-1:0]   mism_q, mism_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic [N_IN-1:0]   chk_j_q, chk_j_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [N_IN-1:0]   cmp_j_q, cmp_j_d;
  logic              cmp_a_q, cmp_a_d;
  logic              cmp_b_q, cmp_b_d;
  logic              tail_vld;
  logic [N_IN-1:0]   tail_idx;

  assign x_valid   = (state_q == SWEEP);
  assign x_out     = idx_q;
  assign busy      = (state_q == SWEEP) || (state_q == DRAIN) || (state_q == CHECK);
  assign done      = (state_q == FIN);
  assign onset_cnt = onset_q;
  assign sym_ok    = sym_q;
  assign mism_idx  = mism_q;

  // Tail of the {valid, idx} pipeline marks which issued minterm y_in belongs to.
  generate
    if (EVAL_LAT == 0) begin : g_nolat
      assign tail_vld = x_valid;
      assign tail_idx = idx_q;
    end else begin : g_lat
      logic [EVAL_LAT-1:0] pv_q;
      logic [N_IN-1:0]     pidx_q [EVAL_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv_q <= '0;
          for (int i = 0; i < EVAL_LAT; i++) pidx_q[i] <= '0;
        end else begin
          pv_q[0]   <= x_valid;
          pidx_q[0] <= idx_q;
          for (int i = 1; i < EVAL_LAT; i++) begin
            pv_q[i]   <= pv_q[i-1];
            pidx_q[i] <= pidx_q[i-1];
          end
        end
      end
      assign tail_vld = pv_q[EVAL_LAT-1];
      assign tail_idx = pidx_q[EVAL_LAT-1];
    end
  endgenerate

`ifdef PLA_SWEEP_CRC_EN
  logic [15:0] crc_q, crc_d, sig_q, sig_d;
  assign sig = sig_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    alpha_d   = alpha_q;
    idx_d     = idx_q;
    tt_d      = tt_q;
    onset_d   = onset_q;
    sym_d     = sym_q;
    mism_d    = mism_q;
    dcnt_d    = dcnt_q;
    chk_j_d   = chk_j_q;
    cmp_vld_d = 1'b0;
    cmp_j_d   = chk_j_q;
    cmp_a_d   = tt_q[chk_j_q];
    cmp_b_d   = tt_q[chk_j_q ^ alpha_q];
`ifdef PLA_SWEEP_CRC_EN
    crc_d     = crc_q;
    sig_d     = sig_q;
    if (tail_vld) crc_d = crc_step(crc_q, y_in);
`endif

    if (tail_vld) begin
      tt_d[tail_idx] = y_in;
      if (y_in) onset_d = onset_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          alpha_d = alpha;
          onset_d = '0;
          sym_d   = 1'b0;
          mism_d  = '0;
          tt_d    = '0;
          idx_d   = '0;
          chk_j_d = '0;
          dcnt_d  = '0;
          state_d = SWEEP;
`ifdef PLA_SWEEP_CRC_EN
          crc_d   = 16'hFFFF;
          sig_d   = 16'h0000;
`endif
        end
      end
      SWEEP: begin
        if (idx_q == IDX_MAX) begin
          if (EVAL_LAT > 0) begin
            state_d = DRAIN;
          end else if (mode_q) begin
            state_d = CHECK;
          end else begin
            state_d = FIN;
            sym_d   = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == 3'(EVAL_LAT - 1)) begin
          if (mode_q) begin
            state_d = CHECK;
          end else begin
            state_d = FIN;
            sym_d   = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      CHECK: begin
        // Table reads are registered; the compare resolves one cycle after the read.
        cmp_vld_d = 1'b1;
        if (chk_j_q != IDX_MAX) chk_j_d = chk_j_q + 1'b1;
        if (cmp_vld_q && (cmp_a_q != cmp_b_q)) begin
          mism_d  = cmp_j_q;
          sym_d   = 1'b0;
          state_d = FIN;
        end else if (cmp_vld_q && (cmp_j_q == IDX_MAX)) begin
          sym_d   = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef PLA_SWEEP_CRC_EN
    if ((state_d == FIN) && (state_q != FIN)) sig_d = crc_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      alpha_q   <= '0;
      idx_q     <= '0;
      tt_q      <= '0;
      onset_q   <= '0;
      sym_q     <= 1'b0;
      mism_q    <= '0;
      dcnt_q    <= '0;
      chk_j_q   <= '0;
      cmp_vld_q <= 1'b0;
      cmp_j_q   <= '0;
      cmp_a_q   <= 1'b0;
      cmp_b_q   <= 1'b0;
`ifdef PLA_SWEEP_CRC_EN
      crc_q     <= 16'hFFFF;
      sig_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      alpha_q   <= alpha_d;
      idx_q     <= idx_d;
      tt_q      <= tt_d;
      onset_q   <= onset_d;
      sym_q     <= sym_d;
      mism_q    <= mism_d;
      dcnt_q    <= dcnt_d;
      chk_j_q   <= chk_j_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_j_q   <= cmp_j_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
`ifdef PLA_SWEEP_CRC_EN
      crc_q     <= crc_d;
      sig_q     <= sig_d;
`endif
    end
  end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb/tb_pla_sweep_ctrl.sv - directed bench for pla_sweep_ctrl at EVAL_LAT 0, 2 and 3
// Unit 0: EVAL_LAT=0, unit 1: EVAL_LAT=2, unit 2: EVAL_LAT=3; each drives a delayed network model.
module tb_pla_sweep_ctrl;
  localparam int N = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_s [3];
  logic         mode_s  [3];
  logic [N-1:0] alpha_s [3];
  logic [N-1:0] x_s     [3];
  logic         xv_s    [3];
  logic         y_s     [3];
  logic         busy_s  [3];
  logic         done_s  [3];
  logic [N:0]   onset_s [3];
  logic         sym_s   [3];
  logic [N-1:0] mism_s  [3];
  int           fsel    [3];
`ifdef PLA_SWEEP_CRC_EN
  logic [15:0]  sig_s   [3];
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic fmodel(input int fs, input logic [N-1:0] x);
    case (fs)
      0:       return x[0] ^ x[1];
      1:       return 1'b1;
      2:       return (x == 9'h1FF);
      default: return 1'b0;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : u
      localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
      logic [3:0] dl = '0;
      logic       f_now;
      assign f_now = fmodel(fsel[g], x_s[g]);
      always @(posedge clk) dl <= {dl[2:0], f_now};
      if (L == 0) begin : g_y0
        assign y_s[g] = f_now;
      end else begin : g_yl
        assign y_s[g] = dl[L-1];
      end
      pla_sweep_ctrl #(.N_IN(N), .EVAL_LAT(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s[g]),
        .mode     (mode_s[g]),
        .alpha    (alpha_s[g]),
        .x_out    (x_s[g]),
        .x_valid  (xv_s[g]),
        .y_in     (y_s[g]),
        .busy     (busy_s[g]),
        .done     (done_s[g]),
        .onset_cnt(onset_s[g]),
        .sym_ok   (sym_s[g]),
        .mism_idx (mism_s[g])
`ifdef PLA_SWEEP_CRC_EN
        ,
        .sig      (sig_s[g])
`endif
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a run on unit u; done cycle is counted from the start edge (E0), -1 if never seen.
  task automatic run(input int u, input int fs, input logic md, input logic [N-1:0] al,
                     input bit poke, output int dcyc, output int xvc);
    fsel[u] = fs;
    @(negedge clk);
    mode_s[u]  = md;
    alpha_s[u] = al;
    start_s[u] = 1'b1;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0;
    mode_s[u]  = ~md;
    alpha_s[u] = ~al;
    dcyc = -1;
    xvc  = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (xv_s[u]) xvc++;
      if (poke) start_s[u] = (k == 40 || k == 41 || k == 300);
      if (done_s[u]) begin
        dcyc = k;
        break;
      end
    end
    start_s[u] = 1'b0;
  endtask

  int dcyc, xvc, w, ndone;
`ifdef PLA_SWEEP_CRC_EN
  logic [15:0] crc_ref;
`endif

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 1'b0;
      alpha_s[i] = '0;
      fsel[i]    = 3;
    end
    repeat (3) @(negedge clk);
    check("rst_x_out",  32'(x_s[0]),     0);
    check("rst_x_valid", 32'(xv_s[0]),   0);
    check("rst_busy",   32'(busy_s[1]),  0);
    check("rst_done",   32'(done_s[2]),  0);
    check("rst_onset",  32'(onset_s[0]), 0);
    check("rst_sym_ok", 32'(sym_s[0]),   0);
    check("rst_mism",   32'(mism_s[0]),  0);
    rst = 1'b0;
    @(negedge clk);

    // y = x0^x1 is symmetric under alpha=3, exhaustive check
    run(0, 0, 1'b1, 9'h003, 1'b0, dcyc, xvc);
    check("t1_done_cycle", dcyc, 1026);
    check("t1_onset", 32'(onset_s[0]), 256);
    check("t1_sym_ok", 32'(sym_s[0]), 1);
    check("t1_mism", 32'(mism_s[0]), 0);
    repeat (3) @(negedge clk);
    check("t1_hold_onset", 32'(onset_s[0]), 256);
    check("t1_hold_done", 32'(done_s[0]), 0);

    // alpha=1 breaks symmetry at x=0
    run(0, 0, 1'b1, 9'h001, 1'b0, dcyc, xvc);
    check("t2_done_cycle", dcyc, 515);
    check("t2_sym_ok", 32'(sym_s[0]), 0);
    check("t2_mism", 32'(mism_s[0]), 0);
    check("t2_onset", 32'(onset_s[0]), 256);

    // constant 1, sweep only, EVAL_LAT=3
    run(2, 1, 1'b0, 9'h0AA, 1'b0, dcyc, xvc);
    check("t3_done_cycle", dcyc, 516);
    check("t3_x_valid_cycles", xvc, 512);
    check("t3_onset", 32'(onset_s[2]), 512);
    check("t3_sym_ok", 32'(sym_s[2]), 1);
    @(negedge clk);
    check("t3_x_out_hold", 32'(x_s[2]), 32'h1FF);

    // single onset minterm 0x1FF, alpha=0x100, EVAL_LAT=2
    run(1, 2, 1'b1, 9'h100, 1'b0, dcyc, xvc);
    check("t4_done_cycle", dcyc, 772);
    check("t4_onset", 32'(onset_s[1]), 1);
    check("t4_sym_ok", 32'(sym_s[1]), 0);
    check("t4_mism", 32'(mism_s[1]), 32'h0FF);

    // abort a sweep with reset at idx 100
    fsel[0] = 0;
    @(negedge clk);
    mode_s[0]  = 1'b1;
    alpha_s[0] = 9'h003;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    w = 0;
    while (x_s[0] != 9'd100 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach_idx", 32'(x_s[0]), 100);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_s[0]), 0);
    check("abort_x_out", 32'(x_s[0]), 0);
    check("abort_onset", 32'(onset_s[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done_s[0]) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // new run, constant 0, with start pulses while busy
    run(0, 3, 1'b0, 9'h000, 1'b1, dcyc, xvc);
    check("t5_done_cycle", dcyc, 513);
    check("t5_onset", 32'(onset_s[0]), 0);
    check("t5_sym_ok", 32'(sym_s[0]), 1);
    check("t5_x_valid_cycles", xvc, 512);
    @(negedge clk);
    check("t5_idle_after", 32'(busy_s[0]), 0);

`ifdef PLA_SWEEP_CRC_EN
    crc_ref = 16'hFFFF;
    for (int i = 0; i < 512; i++)
      crc_ref = {crc_ref[14:0], 1'b0} ^ (crc_ref[15] ? 16'h1021 : 16'h0000);
    check("crc_sig", 32'(sig_s[0]), 32'(crc_ref));
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0]  = 1'b0;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    check("crc_sig_cleared", 32'(sig_s[0]), 0);
    w = 0;
    while (!done_s[0] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("crc_second_done", 32'(done_s[0]), 1);
    check("crc_sig_repeat", 32'(sig_s[0]), 32'(crc_ref));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
